// File: rtl/fmau_sched_if.sv
// Requester-side port bundle for the FMAU scheduler.
// One instance per requester carries its operands, mode, handshake and result.
interface fmau_sched_if;
  logic        valid;
  logic        ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic [31:0] d;
  logic [1:0]  in_pre;
  logic [1:0]  out_pre;
  logic        res_valid;
  logic [31:0] res_data;

  modport master (
    output valid, a, b, c, d, in_pre, out_pre,
    input  ready, res_valid, res_data
  );

  modport slave (
    input  valid, a, b, c, d, in_pre, out_pre,
    output ready, res_valid, res_data
  );
endinterface

// File: rtl/fmau_sched.sv
// Two-requester round-robin issue scheduler for the posit FMA unit.
// Locks the precision mode while operations are in flight and steers results back by tag.

module fmau_sched_lane #(
  parameter logic ID = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_mode,
  input  logic [3:0]  cur_mode,
  input  logic        ret_vld,
  input  logic        ret_id,
  input  logic [31:0] fmau_out,
  output logic        match,
  output logic        res_valid,
  output logic [31:0] res_data
);
  logic res_vld_d, res_vld_q;

  always_comb begin
    match     = (req_mode == cur_mode);
    res_vld_d = ret_vld && (ret_id == ID);
  end

  // The retiring tag is registered so the flag lines up with the FMAU result edge.
  always_ff @(posedge clk) begin
    if (!rst_n) res_vld_q <= 1'b0;
    else        res_vld_q <= res_vld_d;
  end

  assign res_valid = res_vld_q;
  assign res_data  = res_vld_q ? fmau_out : '0;
endmodule

module fmau_sched #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fmau_sched_if.slave rq0,
  fmau_sched_if.slave rq1,
  output logic [31:0] fmau_a,
  output logic [31:0] fmau_b,
  output logic [31:0] fmau_c,
  output logic [31:0] fmau_d,
  output logic [1:0]  fmau_in_pre,
  output logic [1:0]  fmau_out_pre,
  input  logic [31:0] fmau_out,
  output logic        busy
);
  localparam int NREQ = 2;
  localparam int CW   = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                        state_q, state_d;
  logic [NREQ-1:0]               req_vld, gnt, match, res_vld;
  logic [NREQ-1:0][3:0]          req_mode;
  logic [NREQ-1:0][3:0][31:0]    req_opnd;
  logic [NREQ-1:0][31:0]         res_dat;
  logic [3:0][31:0]              opnd_q, opnd_d;
  logic [3:0]                    mode_q, mode_d;
  logic                          prio_q, prio_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [LAT:1]                  vld_pipe_q, vld_pipe_d;
  logic [LAT:1]                  id_pipe_q, id_pipe_d;
  logic                          issue, gnt_id, retire, to_drain, oth;

  // Grants are suppressed while reset is asserted so ready reads 0 during reset.
  assign req_vld     = {rq1.valid, rq0.valid} & {NREQ{rst_n}};
  assign req_mode[0] = {rq0.in_pre, rq0.out_pre};
  assign req_mode[1] = {rq1.in_pre, rq1.out_pre};
  assign req_opnd[0] = {rq0.a, rq0.b, rq0.c, rq0.d};
  assign req_opnd[1] = {rq1.a, rq1.b, rq1.c, rq1.d};
  assign retire      = vld_pipe_q[LAT];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fmau_sched_lane #(.ID(1'(i))) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_mode (req_mode[i]),
      .cur_mode (mode_q),
      .ret_vld  (retire),
      .ret_id   (id_pipe_q[LAT]),
      .fmau_out (fmau_out),
      .match    (match[i]),
      .res_valid(res_vld[i]),
      .res_data (res_dat[i])
    );
  end

  always_comb begin
    gnt      = '0;
    to_drain = 1'b0;
    prio_d   = prio_q;
    mode_d   = mode_q;
    state_d  = state_q;
    opnd_d   = opnd_q;
    oth      = ~prio_q;

    case (state_q)
      S_IDLE: begin
        if (req_vld[prio_q])   gnt[prio_q] = 1'b1;
        else if (req_vld[oth]) gnt[oth]    = 1'b1;
      end
      S_RUN: begin
        // A mismatched head-of-line request blocks the other side so it cannot starve.
        if (req_vld[prio_q]) begin
          if (match[prio_q]) gnt[prio_q] = 1'b1;
          else               to_drain    = 1'b1;
        end else if (req_vld[oth]) begin
          if (match[oth]) gnt[oth] = 1'b1;
          else begin
            to_drain = 1'b1;
            prio_d   = oth;
          end
        end
      end
      default: ;
    endcase

    issue  = |gnt;
    gnt_id = gnt[1];

    cnt_d = cnt_q;
    if (issue && !retire)      cnt_d = cnt_q + 1'b1;
    else if (!issue && retire) cnt_d = cnt_q - 1'b1;

    vld_pipe_d[1] = issue;
    id_pipe_d[1]  = gnt_id;
    for (int j = 2; j <= LAT; j++) begin
      vld_pipe_d[j] = vld_pipe_q[j-1];
      id_pipe_d[j]  = id_pipe_q[j-1];
    end

    if (issue) begin
      prio_d = ~gnt_id;
      opnd_d = req_opnd[gnt_id];
    end

    case (state_q)
      S_IDLE: begin
        if (issue) begin
          mode_d  = req_mode[gnt_id];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!issue && cnt_d == '0) state_d = S_IDLE;
        else if (to_drain)         state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_d == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      mode_q     <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      opnd_q     <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
      opnd_q     <= opnd_d;
    end
  end

  assign rq0.ready     = gnt[0];
  assign rq1.ready     = gnt[1];
  assign rq0.res_valid = res_vld[0];
  assign rq1.res_valid = res_vld[1];
  assign rq0.res_data  = res_dat[0];
  assign rq1.res_data  = res_dat[1];

  assign fmau_a       = opnd_q[3];
  assign fmau_b       = opnd_q[2];
  assign fmau_c       = opnd_q[1];
  assign fmau_d       = opnd_q[0];
  assign fmau_in_pre  = mode_q[3:2];
  assign fmau_out_pre = mode_q[1:0];
  assign busy         = (cnt_q != '0) || (state_q == S_DRAIN);
endmodule

// File: tb/tb_fmau_sched.sv
// Bench for fmau_sched: directed scenarios plus random traffic against a
// scoreboard model built from issue history (in-flight count = issues in the last LAT edges).
module tb_fmau_sched;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmau_sched_if rq0 ();
  fmau_sched_if rq1 ();
  logic [31:0] fmau_a, fmau_b, fmau_c, fmau_d, fmau_out;
  logic [1:0]  fmau_in_pre, fmau_out_pre;
  logic        busy;

  fmau_sched #(.LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rq0         (rq0),
    .rq1         (rq1),
    .fmau_a      (fmau_a),
    .fmau_b      (fmau_b),
    .fmau_c      (fmau_c),
    .fmau_d      (fmau_d),
    .fmau_in_pre (fmau_in_pre),
    .fmau_out_pre(fmau_out_pre),
    .fmau_out    (fmau_out),
    .busy        (busy)
  );

  // Behavioural FMAU: result of the operands latched at edge k appears after edge k+LAT.
  logic [31:0] fpipe [1:LAT];
  always @(posedge clk) begin
    fpipe[1] <= fmau_a * fmau_b + fmau_c * fmau_d;
    for (int j = 2; j <= LAT; j++) fpipe[j] <= fpipe[j-1];
  end
  assign fmau_out = fpipe[LAT];

  function automatic logic [31:0] fma(input logic [127:0] o);
    return o[127:96] * o[95:64] + o[63:32] * o[31:0];
  endfunction

  typedef struct {
    int          edge_n;
    bit          id;
    logic [31:0] data;
  } iss_t;

  iss_t       hist[$];
  int         ecount, checks, errors;
  logic [3:0] m_mode;
  bit         m_prio, m_drain;
  int         last_gnt_edge [2];
  int         prio1_edge, g1_edge;
  bit         got1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int inflight(input int e);
    int n = 0;
    foreach (hist[i]) if (hist[i].edge_n > e - LAT) n++;
    return n;
  endfunction

  task automatic drive0(input bit v, input logic [3:0] md);
    rq0.valid = v;
    {rq0.in_pre, rq0.out_pre} = md;
    rq0.a = $urandom; rq0.b = $urandom; rq0.c = $urandom; rq0.d = $urandom;
  endtask

  task automatic drive1(input bit v, input logic [3:0] md);
    rq1.valid = v;
    {rq1.in_pre, rq1.out_pre} = md;
    rq1.a = $urandom; rq1.b = $urandom; rq1.c = $urandom; rq1.d = $urandom;
  endtask

  // One clock: predict and check grants before the edge, then update the model and
  // check registered outputs and results just after it.
  task automatic tick();
    int           cnt, ncnt, g;
    bit           v [2];
    bit           set_drain, np, old_prio;
    logic [3:0]   rm [2];
    logic [127:0] ops [2];
    logic [1:0]   er;
    logic [31:0]  ed [2];
    iss_t         rec;

    @(negedge clk);
    v[0]   = rq0.valid;
    v[1]   = rq1.valid;
    rm[0]  = {rq0.in_pre, rq0.out_pre};
    rm[1]  = {rq1.in_pre, rq1.out_pre};
    ops[0] = {rq0.a, rq0.b, rq0.c, rq0.d};
    ops[1] = {rq1.a, rq1.b, rq1.c, rq1.d};
    cnt = inflight(ecount);
    g = -1;
    set_drain = 1'b0;
    np = m_prio;
    if (rst_n) begin
      if (cnt == 0) begin
        if (v[m_prio])       g = int'(m_prio);
        else if (v[!m_prio]) g = int'(!m_prio);
      end else if (!m_drain) begin
        if (v[m_prio]) begin
          if (rm[m_prio] == m_mode) g = int'(m_prio);
          else                      set_drain = 1'b1;
        end else if (v[!m_prio]) begin
          if (rm[!m_prio] == m_mode) g = int'(!m_prio);
          else begin
            set_drain = 1'b1;
            np = !m_prio;
          end
        end
      end
    end
    chk("r0_ready", rq0.ready, g == 0);
    chk("r1_ready", rq1.ready, g == 1);

    @(posedge clk);
    ecount++;
    #1;
    if (!rst_n) begin
      hist.delete();
      m_mode = '0;
      m_prio = 1'b0;
      m_drain = 1'b0;
      chk("rst_operands", {fmau_a, fmau_b, fmau_c, fmau_d}, '0);
      chk("rst_mode", {fmau_in_pre, fmau_out_pre}, '0);
      chk("rst_results", {rq0.res_valid, rq1.res_valid, rq0.res_data, rq1.res_data}, '0);
      chk("rst_busy", busy, 1'b0);
      return;
    end

    old_prio = m_prio;
    m_prio = np;
    if (g >= 0) begin
      if (cnt == 0) m_mode = rm[g];
      m_prio = (g == 0);
      rec.edge_n = ecount;
      rec.id = g[0];
      rec.data = fma(ops[g]);
      hist.push_back(rec);
      last_gnt_edge[g] = ecount;
      if (g == 1 && !got1) begin
        got1 = 1'b1;
        g1_edge = ecount;
      end
      chk("issue_operands", {fmau_a, fmau_b, fmau_c, fmau_d}, ops[g]);
    end
    if (!old_prio && m_prio) prio1_edge = ecount;
    if (set_drain) m_drain = 1'b1;
    ncnt = inflight(ecount);
    if (ncnt == 0) m_drain = 1'b0;
    chk("busy", busy, (ncnt != 0) || m_drain);
    chk("mode", {fmau_in_pre, fmau_out_pre}, m_mode);

    er = '0;
    ed[0] = '0;
    ed[1] = '0;
    foreach (hist[i]) begin
      if (hist[i].edge_n == ecount - LAT) begin
        er[hist[i].id] = 1'b1;
        ed[hist[i].id] = hist[i].data;
      end
    end
    chk("res0", {rq0.res_valid, rq0.res_data}, {er[0], ed[0]});
    chk("res1", {rq1.res_valid, rq1.res_data}, {er[1], ed[1]});
    while (hist.size() > 0 && hist[0].edge_n <= ecount - LAT) void'(hist.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive0(1'b0, 4'h0);
      drive1(1'b0, 4'h0);
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ecount = 0;
    m_mode = '0;
    m_prio = 1'b0;
    m_drain = 1'b0;
    got1 = 1'b0;
    prio1_edge = 0;
    g1_edge = 0;
    last_gnt_edge[0] = 0;
    last_gnt_edge[1] = 0;
    drive0(1'b0, 4'h0);
    drive1(1'b0, 4'h0);

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    idle(2);

    // Streaming: r0 alone, 8 ops in mode 00; issue and retire overlap from the 5th op on.
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, 4'h0);
      tick();
    end
    chk("stream_last_edge", last_gnt_edge[0], ecount);
    idle(LAT + 3);

    // Round-robin: both valid in mode 00.
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, 4'h0);
      drive1(1'b1, 4'h0);
      tick();
    end
    idle(LAT + 3);

    // Mode change: 3 ops from r0 in mode 00, then r1 asks for mode 10.
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 4'h0);
      drive1(1'b0, 4'h0);
      tick();
    end
    got1 = 1'b0;
    for (int i = 0; i < 20 && !got1; i++) begin
      drive0(1'b0, 4'h0);
      drive1(1'b1, 4'b1000);
      tick();
    end
    chk("modesw_granted", got1, 1'b1);
    chk("modesw_gap", g1_edge - last_gnt_edge[0], LAT + 1);
    idle(LAT + 3);

    // Starvation: r0 floods mode 00 while r1 wants mode 01.
    got1 = 1'b0;
    for (int i = 0; i < 20 && !got1; i++) begin
      drive0(1'b1, 4'h0);
      drive1(1'b1, 4'b0001);
      tick();
    end
    chk("starve_granted", got1, 1'b1);
    chk("starve_bound", (g1_edge - prio1_edge) <= LAT + 2, 1'b1);
    for (int i = 0; i < 12; i++) begin
      drive0(1'b1, 4'h0);
      drive1(1'b1, 4'b0001);
      tick();
    end
    idle(LAT + 3);

    // Reset with 3 operations in flight; lost results must never appear.
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 4'h0);
      drive1(1'b0, 4'h0);
      tick();
    end
    drive0(1'b0, 4'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive0(1'b1, 4'h0);
    drive1(1'b1, 4'h0);
    tick();
    chk("post_rst_r0_first", last_gnt_edge[0], ecount);
    idle(LAT + 3);

    // Random traffic with occasional mode changes.
    for (int i = 0; i < 400; i++) begin
      drive0($urandom_range(0, 9) < 7, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
      drive1($urandom_range(0, 9) < 7, ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
      tick();
    end
    idle(LAT + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
